// File: rtl/memory_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder_pkg
//  Description : Shared types and helpers for the memory responder: reset
//                instruction value, slot encoding and byte-lane rotation
//                between word order and bank order.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_responder_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hC800_0000;

   // Slot alternates every mem_clk edge; fetch slot comes first after reset.
   typedef enum logic {
      SLOT_FETCH = 1'b0,
      SLOT_DATA  = 1'b1
   } slot_e;

   // Word order -> bank order: bank b holds word byte (b - off) mod 4.
   function automatic logic [31:0] lane_rotate(input logic [31:0] word,
                                               input logic [1:0]  off);
      logic [31:0] lanes;
      logic [1:0]  k;
      lanes = '0;
      for (int b = 0; b < 4; b++) begin
         k = 2'(b) - off;
         lanes[8*b +: 8] = word[8*k +: 8];
      end
      return lanes;
   endfunction

   // Bank order -> word order: word byte k comes from bank (off + k) mod 4.
   function automatic logic [31:0] lane_unrotate(input logic [31:0] lanes,
                                                 input logic [1:0]  off);
      logic [31:0] word;
      logic [1:0]  bnk;
      word = '0;
      for (int k = 0; k < 4; k++) begin
         bnk = 2'(k) + off;
         word[8*k +: 8] = lanes[8*bnk +: 8];
      end
      return word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_responder_byte_bank.sv
`default_nettype none
// ============================================================================
//  Module      : byte_bank
//  Description : Single-port 8-bit RAM, synchronous read-first, one lane of
//                the responder's byte storage. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_bank #(
   parameter int ROW_W = 14
) (
   input  logic             mem_clk,
   input  logic             we_i,
   input  logic [ROW_W-1:0] row_i,
   input  logic [7:0]       d_i,
   output logic [7:0]       q_o
);

   logic [7:0] mem_q [0:(1<<ROW_W)-1];

   // Read-first: q_o returns the old byte when a write hits the same row.
   always_ff @(posedge mem_clk) begin
      if (we_i) begin
         mem_q[row_i] <= d_i;
      end
      q_o <= mem_q[row_i];
   end

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder
//  Description : Fetch/data memory responder. Four byte banks are shared
//                between a fetch slot and a data slot on alternate mem_clk
//                edges; a byte-wide preload port pre-empts either slot.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              mem_clk,
   input  logic              nreset,
   input  logic              instruction_memory_en,
   input  logic [31:0]       instruction_memory_a,
   output logic [31:0]       instruction_memory_v,
   input  logic              data_memory_read,
   input  logic              data_memory_write,
   input  logic [31:0]       data_memory_a,
   input  logic [31:0]       data_memory_out_v,
   output logic [31:0]       data_memory_in_v,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_a,
   input  logic [7:0]        load_d,
   output logic              slot,
   output logic              load_collision
);

   localparam int ROW_W = ADDR_W - 2;

   slot_e             slot_q, slot_d;
   logic              pend_fetch_q, pend_fetch_d;
   logic              pend_read_q, pend_read_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       imem_q, imem_d;
   logic [31:0]       dmem_q, dmem_d;
   logic              coll_q, coll_d;

   logic [ADDR_W-1:0] req_a;
   logic [1:0]        req_off;
   logic              req_pending;
   logic              wr_now;
   logic [31:0]       wr_lanes;
   logic [31:0]       bank_word;
   logic [7:0]        bank_q [4];

   // Upper address bits carry no meaning in this memory.
   logic              w_unused_addr;
   assign w_unused_addr = ^{instruction_memory_a[31:ADDR_W], data_memory_a[31:ADDR_W]};

   // Slot request mux: select the address and decide whether a request is live.
   always_comb begin
      req_a       = (slot_q == SLOT_DATA) ? data_memory_a[ADDR_W-1:0]
                                          : instruction_memory_a[ADDR_W-1:0];
      req_off     = req_a[1:0];
      req_pending = (slot_q == SLOT_DATA) ? (data_memory_read | data_memory_write)
                                          : instruction_memory_en;
      wr_now      = (slot_q == SLOT_DATA) & data_memory_write & ~load_en;
      wr_lanes    = lane_rotate(data_memory_out_v, req_off);
      bank_word   = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};
   end

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_bank
         logic             bank_we;
         logic [ROW_W-1:0] bank_row;
         logic [7:0]       bank_d;
         logic [1:0]       lane_k;

         // Per-bank address: an unaligned word spans two rows, so each lane
         // computes its own byte address; preload overrides the slot access.
         always_comb begin
            lane_k = 2'(b) - req_off;
            if (load_en) begin
               bank_we  = (load_a[1:0] == 2'(b));
               bank_row = load_a[ADDR_W-1:2];
               bank_d   = load_d;
            end else begin
               bank_we  = wr_now;
               bank_row = ROW_W'((req_a + ADDR_W'(lane_k)) >> 2);
               bank_d   = wr_lanes[8*b +: 8];
            end
         end

         byte_bank #(.ROW_W(ROW_W)) u_bank (
            .mem_clk (mem_clk),
            .we_i    (bank_we),
            .row_i   (bank_row),
            .d_i     (bank_d),
            .q_o     (bank_q[b])
         );
      end
   endgenerate

   // Next state: slot toggle, pending-read bookkeeping, output capture, sticky flag.
   always_comb begin
      slot_d       = (slot_q == SLOT_FETCH) ? SLOT_DATA : SLOT_FETCH;
      pend_fetch_d = ~load_en & (slot_q == SLOT_FETCH) & instruction_memory_en;
      pend_read_d  = ~load_en & (slot_q == SLOT_DATA)  & data_memory_read;
      off_d        = req_off;
      imem_d       = imem_q;
      dmem_d       = dmem_q;
      coll_d       = coll_q | (load_en & req_pending);
      if (pend_fetch_q) begin
         imem_d = lane_unrotate(bank_word, off_q);
      end
      if (pend_read_q) begin
         dmem_d = lane_unrotate(bank_word, off_q);
      end
   end

   // State registers; outputs return to reset values as soon as nreset falls.
   always_ff @(posedge mem_clk or negedge nreset) begin
      if (!nreset) begin
         slot_q       <= SLOT_FETCH;
         pend_fetch_q <= 1'b0;
         pend_read_q  <= 1'b0;
         off_q        <= 2'd0;
         imem_q       <= NOP_INSTR;
         dmem_q       <= 32'd0;
         coll_q       <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         pend_fetch_q <= pend_fetch_d;
         pend_read_q  <= pend_read_d;
         off_q        <= off_d;
         imem_q       <= imem_d;
         dmem_q       <= dmem_d;
         coll_q       <= coll_d;
      end
   end

   assign instruction_memory_v = imem_q;
   assign data_memory_in_v     = dmem_q;
   assign slot                 = slot_q;
   assign load_collision       = coll_q;

endmodule
`default_nettype wire

// File: doc/memory_responder.md
# memory_responder

Synthesizable responder for the CPU's instruction-fetch and data-memory interfaces: byte-addressed, little-endian, word-wide access at any byte alignment. It replaces the behavioural memory model with RTL that FPGA builds can use. Byte storage is split into four single-port banks, time-shared between a fetch slot and a data slot on alternating mem_clk edges. A byte-wide preload port fills memory with the program image.

## Interface
Parameters:
- ADDR_W, 16, byte-address width; capacity 2^ADDR_W bytes.
- NOP_INSTR, 32'hC8000000, instruction value driven during and after reset.

Ports:
- mem_clk  in  1  memory clock, 2× core_clk; rising edges alternate fetch/data slots.
- nreset  in  1  asynchronous, active-low reset.
- instruction_memory_en  in  1  fetch request, sampled in the fetch slot.
- instruction_memory_a  in  32  fetch byte address; only [ADDR_W-1:0] used.
- instruction_memory_v  out  32  fetched word, registered.
- data_memory_read  in  1  data read request, sampled in the data slot.
- data_memory_write  in  1  data write request, sampled in the data slot.
- data_memory_a  in  32  data byte address; only [ADDR_W-1:0] used.
- data_memory_out_v  in  32  write data from the CPU.
- data_memory_in_v  out  32  read data to the CPU, registered.
- load_en  in  1  preload byte write strobe.
- load_a  in  ADDR_W  preload byte address.
- load_d  in  8  preload byte.
- slot  out  1  current slot: 0 = fetch, 1 = data.
- load_collision  out  1  sticky flag: a preload pre-empted a pending request.

## Operation
- Reset values: instruction_memory_v = NOP_INSTR; data_memory_in_v = 0; slot = 0; load_collision = 0. Memory contents are not reset.
- slot toggles on every mem_clk edge after reset release. The first edge after release is a fetch slot.
- Byte mapping for a word access at address A: byte k (k = 0..3) sits at address (A+k) mod 2^ADDR_W, in bank (A+k)[1:0], row (A+k)[ADDR_W-1:2]. Byte k maps to word bits [8k+7:8k].
- Fetch slot: if instruction_memory_en = 1, read all four banks and register the rotated word into instruction_memory_v. Otherwise hold the output.
- Data slot, read only: register the rotated word into data_memory_in_v.
- Data slot, write only: write the four bytes of data_memory_out_v. data_memory_in_v holds.
- Data slot, read and write together: the read returns the pre-write contents (read-before-write), and the write commits on the same edge.
- Data slot, no request: data_memory_in_v holds.
- Preload: when load_en = 1, the single byte write has priority over the slot's access in every cycle.
  - A slot access with a request pending is skipped. Its output holds and load_collision sets until reset.
  - Preload is accepted while nreset = 0; the banks are not held in reset.
- Wrap-around: an access at 2^ADDR_W-1 reads bytes 2^ADDR_W-1, 0, 1, 2 (modulo addressing).
- Upper address bits [31:ADDR_W] are ignored; there is no out-of-range error.

## Timing
- Read latency: result is visible one mem_clk edge after the slot edge that samples the request. From the CPU, this is valid before the next core_clk rising edge.
- A write performed in slot n is visible to a fetch in slot n+1.
- A fetch and a write to the same bytes in adjacent slots resolve in slot order; there are no same-edge conflicts by construction.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous). A write on the edge coinciding with reset assertion is not guaranteed; all other bank contents are preserved.

## Structure
- Shared package: NOP_INSTR default, slot encoding constants (FETCH=0, DATA=1), and lane-rotate/unrotate functions mapping bytes ⇄ banks by A[1:0].
- One sub-module, byte_bank: single-port 8-bit RAM, 2^(ADDR_W-2) deep, synchronous read, write enable. Instantiate four, one per lane. Each bank gets its own row address, since an unaligned access spans two rows.
- The top level holds the slot toggle, request mux, preload priority, rotation, and output registers.

## Test plan
- Reset: hold nreset = 0 → instruction_memory_v = 32'hC8000000, data_memory_in_v = 0, slot = 0, load_collision = 0. Release → slot toggles every edge.
- Preload then fetch: preload bytes 78, 56, 34, 12 at 0x0010..0x0013 with nreset low, then fetch 0x10 → instruction_memory_v = 32'h12345678 one edge after the fetch slot.
- Unaligned write/read: write 32'hAABBCCDD at 0x0003, then read 0x0002 → 32'hBBCCDDxx (xx = old byte at 0x0002), and read 0x0003 → 32'hAABBCCDD.
- Wrap: write 32'h11223344 at 0xFFFE → bytes 0xFFFE = 44, 0xFFFF = 33, 0x0000 = 22, 0x0001 = 11. Read 0xFFFE → 32'h11223344.
- Read and write together: memory at 0x20 = 32'h0; assert read and write at 0x20 with 32'hDEADBEEF → data_memory_in_v = 0; next read → 32'hDEADBEEF.
- Collision and mid-op reset: assert load_en in a fetch slot with en = 1 → instruction_memory_v holds, load_collision = 1. Pulse nreset low → flag clears, previously loaded bytes remain readable.
